// File: rtl/pmp_formal_pkg.sv
// Shared PMP definitions: CSR base numbers, CSR-access FSM states, cfg byte layout.
package pmp_formal_pkg;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        FLUSH_WAIT
    } pmp_csr_state_e;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_addr_mode_e;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_e addr_mode;
        logic           x;
        logic           w;
        logic           r;
    } pmpcfg_t;

    function automatic int entries_per_cfg(input int xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/pmp_cfg_legalize.sv
// WARL legalisation of one pmpcfg byte; a locked byte keeps its old value.
// With PMP_NO_NA4_EN defined, NA4 requests fall back to OFF (8-byte minimum granularity).
module pmp_cfg_legalize
    import pmp_formal_pkg::*;
(
    input  logic [7:0] old_cfg,
    input  logic [7:0] new_cfg,
    input  logic       locked,
    output logic [7:0] legal_cfg
);

    pmpcfg_t req;
    pmpcfg_t fixed;

    always_comb begin
        req            = pmpcfg_t'(new_cfg);
        fixed          = req;
        fixed.reserved = 2'b00;
        if (!req.r) begin
            fixed.w = 1'b0;
        end
`ifdef PMP_NO_NA4_EN
        if (req.addr_mode == A_NA4) begin
            fixed.addr_mode = A_OFF;
        end
`endif
        if (locked) begin
            legal_cfg = old_cfg;
        end else begin
            legal_cfg = fixed;
        end
    end

endmodule

// File: rtl/pmp_csr_regfile.sv
// PMP CSR register file: pmpcfg*/pmpaddr* accesses with lock and WARL rules plus a flush handshake.
// Optional macro PMP_NO_NA4_EN (applied in pmp_cfg_legalize) legalises NA4 writes to OFF.
module pmp_csr_regfile
    import pmp_formal_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int PLEN           = 34,
    parameter int NR_PMP_ENTRIES = 4,
    parameter int STORE_ENTRIES  = (NR_PMP_ENTRIES > 0) ? NR_PMP_ENTRIES : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                csr_req_i,
    output logic                                csr_gnt_o,
    input  logic                                csr_we_i,
    input  logic [11:0]                         csr_addr_i,
    input  logic [XLEN-1:0]                     csr_wdata_i,
    output logic [XLEN-1:0]                     csr_rdata_o,
    output logic                                csr_done_o,
    output logic                                csr_err_o,
    output logic                                flush_req_o,
    input  logic                                flush_ack_i,
    output logic [STORE_ENTRIES-1:0][7:0]       pmpcfg_o,
    output logic [STORE_ENTRIES-1:0][PLEN-3:0]  pmpaddr_o
);

    localparam int EPC = entries_per_cfg(XLEN);

    pmp_csr_state_e                     state_q;
    logic                               req_we_q;
    logic [11:0]                        req_addr_q;
    logic [XLEN-1:0]                    req_wdata_q;
    pmpcfg_t [STORE_ENTRIES-1:0]        cfg_q;
    pmpcfg_t [STORE_ENTRIES-1:0]        cfg_d;
    logic [STORE_ENTRIES-1:0][PLEN-3:0] pmpaddr_q;
    logic [STORE_ENTRIES-1:0][PLEN-3:0] pmpaddr_d;
    logic                               cfg_hit;
    logic                               addr_hit;
    logic                               apply_write;
    logic                               changed;
    logic [1:0]                         cfg_grp;
    logic [XLEN-1:0]                    rdata_mux;

    // RV64 only has even pmpcfg numbers; cfg_grp is the group of EPC entries a CSR covers.
    assign cfg_hit     = (req_addr_q[11:4] == CSR_PMPCFG0[11:4]) && (req_addr_q[3:2] == 2'b00)
                         && ((XLEN == 32) || !req_addr_q[0]);
    assign addr_hit    = (req_addr_q[11:4] == CSR_PMPADDR0[11:4]);
    assign cfg_grp     = (XLEN == 32) ? req_addr_q[1:0] : {1'b0, req_addr_q[1]};
    assign apply_write = (state_q == APPLY) && req_we_q;

    for (genvar i = 0; i < STORE_ENTRIES; i++) begin : g_entry
        localparam int LANE = i % EPC;
        localparam int GRP  = i / EPC;
        localparam bit IMPL = (i < NR_PMP_ENTRIES);
        logic [7:0] legal_cfg;
        logic       cfg_sel;
        logic       addr_sel;
        logic       addr_locked;

        pmp_cfg_legalize u_legalize (
            .old_cfg   (cfg_q[i]),
            .new_cfg   (req_wdata_q[LANE*8 +: 8]),
            .locked    (cfg_q[i].locked),
            .legal_cfg (legal_cfg)
        );

        // A locked TOR entry above also freezes this entry's address (its lower bound).
        if (i < NR_PMP_ENTRIES - 1) begin : g_tor
            assign addr_locked = cfg_q[i].locked ||
                                 (cfg_q[i+1].locked && (cfg_q[i+1].addr_mode == A_TOR));
        end else begin : g_last
            assign addr_locked = cfg_q[i].locked;
        end

        assign cfg_sel      = IMPL && apply_write && cfg_hit && (int'(cfg_grp) == GRP);
        assign addr_sel     = IMPL && apply_write && addr_hit && (int'(req_addr_q[3:0]) == i)
                              && !addr_locked;
        assign cfg_d[i]     = cfg_sel ? pmpcfg_t'(legal_cfg) : cfg_q[i];
        assign pmpaddr_d[i] = addr_sel ? req_wdata_q[PLEN-3:0] : pmpaddr_q[i];
    end

    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NR_PMP_ENTRIES; i++) begin
            if (cfg_hit && (int'(cfg_grp) == i / EPC)) begin
                rdata_mux[(i % EPC)*8 +: 8] = cfg_q[i];
            end
            if (addr_hit && (int'(req_addr_q[3:0]) == i)) begin
                rdata_mux = XLEN'(pmpaddr_q[i]);
            end
        end
    end

    assign changed   = (cfg_d != cfg_q) || (pmpaddr_d != pmpaddr_q);
    assign pmpcfg_o  = cfg_q;
    assign pmpaddr_o = pmpaddr_q;
    // No grant in the done cycle, so back-to-back requests start one cycle after completion.
    assign csr_gnt_o = !rst_i && csr_req_i && (state_q == IDLE) && !csr_done_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            cfg_q       <= '0;
            pmpaddr_q   <= '0;
            csr_rdata_o <= '0;
            csr_done_o  <= 1'b0;
            csr_err_o   <= 1'b0;
            flush_req_o <= 1'b0;
        end else begin
            csr_rdata_o <= '0;
            csr_done_o  <= 1'b0;
            csr_err_o   <= 1'b0;
            cfg_q       <= cfg_d;
            pmpaddr_q   <= pmpaddr_d;
            case (state_q)
                IDLE: begin
                    if (csr_gnt_o) begin
                        req_we_q    <= csr_we_i;
                        req_addr_q  <= csr_addr_i;
                        req_wdata_q <= csr_wdata_i;
                        state_q     <= APPLY;
                    end
                end
                APPLY: begin
                    if (!(cfg_hit || addr_hit)) begin
                        csr_err_o  <= 1'b1;
                        csr_done_o <= 1'b1;
                        state_q    <= IDLE;
                    end else if (!req_we_q) begin
                        csr_rdata_o <= rdata_mux;
                        csr_done_o  <= 1'b1;
                        state_q     <= IDLE;
                    end else if (changed) begin
                        flush_req_o <= 1'b1;
                        state_q     <= FLUSH_WAIT;
                    end else begin
                        csr_done_o <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                FLUSH_WAIT: begin
                    if (flush_ack_i) begin
                        flush_req_o <= 1'b0;
                        csr_done_o  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_csr_regfile.sv
// Scoreboard bench for pmp_csr_regfile (RV32, PLEN=34, 4 entries); honours PMP_NO_NA4_EN.
module tb_pmp_csr_regfile;

    localparam int XLEN = 32;
    localparam int PLEN = 34;
    localparam int NR   = 4;
`ifdef PMP_NO_NA4_EN
    localparam bit NA4_OFF = 1'b1;
`else
    localparam bit NA4_OFF = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          gnt_cycle;
        int          lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              csr_req = 1'b0;
    logic              csr_we = 1'b0;
    logic [11:0]       csr_addr = '0;
    logic [XLEN-1:0]   csr_wdata = '0;
    logic              flush_ack = 1'b0;
    logic              csr_gnt_o;
    logic [XLEN-1:0]   csr_rdata_o;
    logic              csr_done_o;
    logic              csr_err_o;
    logic              flush_req_o;
    logic [NR-1:0][7:0]      pmpcfg;
    logic [NR-1:0][PLEN-3:0] pmpaddr;

    exp_t sb[$];
    int   cycle = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic done_seen;

    pmp_csr_regfile #(
        .XLEN           (XLEN),
        .PLEN           (PLEN),
        .NR_PMP_ENTRIES (NR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .csr_req_i   (csr_req),
        .csr_gnt_o   (csr_gnt_o),
        .csr_we_i    (csr_we),
        .csr_addr_i  (csr_addr),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata_o),
        .csr_done_o  (csr_done_o),
        .csr_err_o   (csr_err_o),
        .flush_req_o (flush_req_o),
        .flush_ack_i (flush_ack),
        .pmpcfg_o    (pmpcfg),
        .pmpaddr_o   (pmpaddr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared += 1;
        if (actual !== expected) begin
            mismatched += 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every completion pops the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && csr_done_o) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("rdata", csr_rdata_o, e.rdata);
                checkOutput("err", csr_err_o, e.err);
                if (e.lat != 0) checkOutput("latency", cycle - e.gnt_cycle, e.lat);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input logic exp_flush, input int ack_delay);
        logic got_gnt, got_done, saw_flush;
        @(negedge clk);
        csr_req = 1'b1; csr_we = we; csr_addr = addr; csr_wdata = wdata;
        got_gnt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (csr_gnt_o) begin got_gnt = 1'b1; break; end
            @(negedge clk);
        end
        checkOutput("grant", got_gnt, 1);
        if (!got_gnt) begin csr_req = 1'b0; return; end
        sb.push_back('{rdata: exp_rdata, err: exp_err, gnt_cycle: cycle, lat: (exp_flush ? 0 : 2)});
        @(negedge clk);
        csr_req = 1'b0;
        got_done = 1'b0; saw_flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (csr_done_o) begin got_done = 1'b1; break; end
            if (flush_req_o) begin saw_flush = 1'b1; break; end
        end
        checkOutput("flush_req", saw_flush, exp_flush);
        if (saw_flush) begin
            repeat (ack_delay) begin
                @(negedge clk);
                checkOutput("flush_hold", {csr_done_o, flush_req_o}, 2'b01);
            end
            flush_ack = 1'b1;
            @(negedge clk);
            flush_ack = 1'b0;
            checkOutput("done_on_ack", csr_done_o, 1);
            checkOutput("flush_drop", flush_req_o, 0);
        end else begin
            checkOutput("done_direct", got_done, 1);
        end
    endtask

    initial begin
        csr_req = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_gnt", csr_gnt_o, 0);
        checkOutput("rst_done", csr_done_o, 0);
        checkOutput("rst_err", csr_err_o, 0);
        checkOutput("rst_flush", flush_req_o, 0);
        checkOutput("rst_rdata", csr_rdata_o, 0);
        checkOutput("rst_cfg", pmpcfg, 0);
        checkOutput("rst_addr0", pmpaddr[0], 0);
        csr_req = 1'b0;
        rst = 1'b0;

        applyStimulus(1'b0, 12'h3B0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
        csr_req = 1'b1; csr_we = 1'b0; csr_addr = 12'h3B0;
        #1 checkOutput("no_gnt_on_done", csr_gnt_o, 0);
        csr_req = 1'b0;

        applyStimulus(1'b1, 12'h3A0, 32'h0000_0F0B, 32'h0, 1'b0, 1'b1, 2);
        checkOutput("cfg_0f0b", pmpcfg, 32'h0000_0F0B);
        applyStimulus(1'b0, 12'h3A0, 32'h0, 32'h0000_0F0B, 1'b0, 1'b0, 0);

        applyStimulus(1'b1, 12'h3A0, 32'h0000_8800, 32'h0, 1'b0, 1'b1, 0);
        checkOutput("cfg_lock_tor", pmpcfg, 32'h0000_8800);
        applyStimulus(1'b1, 12'h3B0, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 0);
        checkOutput("addr0_tor_locked", pmpaddr[0], 0);
        applyStimulus(1'b1, 12'h3A0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
        checkOutput("cfg1_locked", pmpcfg, 32'h0000_8800);
        applyStimulus(1'b1, 12'h3B1, 32'h0000_5678, 32'h0, 1'b0, 1'b0, 0);
        checkOutput("addr1_locked", pmpaddr[1], 0);

        applyStimulus(1'b1, 12'h3B2, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1);
        checkOutput("addr2_write", pmpaddr[2], 32'hFFFF_FFFF);
        applyStimulus(1'b0, 12'h3B2, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);

        applyStimulus(1'b1, 12'h3A0, 32'h1002_0000, 32'h0, 1'b0, !NA4_OFF, 0);
        checkOutput("cfg_w_no_r_na4", pmpcfg, NA4_OFF ? 32'h0000_8800 : 32'h1000_8800);
        applyStimulus(1'b1, 12'h3A0, 32'h0067_0000, 32'h0, 1'b0, 1'b1, 0);
        checkOutput("cfg_reserved", pmpcfg, 32'h0007_8800);
        applyStimulus(1'b0, 12'h3A0, 32'h0, 32'h0007_8800, 1'b0, 1'b0, 0);

        applyStimulus(1'b0, 12'h3A1, 32'h0, 32'h0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 12'h3A4, 32'h0, 32'h0, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 12'h3A4, 32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 0);
        checkOutput("cfg_after_err", pmpcfg, 32'h0007_8800);
        applyStimulus(1'b0, 12'h3C0, 32'h0, 32'h0, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 12'h3B5, 32'h0000_ABCD, 32'h0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 12'h3B5, 32'h0, 32'h0, 1'b0, 1'b0, 0);

        // Reset while waiting for the flush acknowledge.
        @(negedge clk);
        csr_req = 1'b1; csr_we = 1'b1; csr_addr = 12'h3B3; csr_wdata = 32'h77;
        #1 checkOutput("gnt_before_rst", csr_gnt_o, 1);
        @(negedge clk);
        csr_req = 1'b0;
        @(negedge clk);
        checkOutput("flush_before_rst", flush_req_o, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_flush_drop", flush_req_o, 0);
        checkOutput("rst_cfg_clear", pmpcfg, 0);
        checkOutput("rst_addr2_clear", pmpaddr[2], 0);
        done_seen = 1'b0;
        repeat (2) @(negedge clk) done_seen |= csr_done_o;
        rst = 1'b0;
        repeat (3) @(negedge clk) done_seen |= csr_done_o;
        checkOutput("no_done_after_rst", done_seen, 0);
        applyStimulus(1'b0, 12'h3B3, 32'h0, 32'h0, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
